axi_slave_write_ctrl: RTL and testbench
=======================================

AXI_SLAVE_WRITE_CTRL -- requirements
Module: axi_slave_write_ctrl

Interface
REQ-001 Parameter ID_W, default 12, AXI ID width.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; legal values 32, 64, 128.
REQ-004 Parameter DEPTH, default 4, AW-queue and B-queue depth; power of 2, >=2.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 s_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-007 s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  AW payload.
REQ-008 s_axi_awvalid  in  1; s_axi_awready  out  1  AW handshake.
REQ-009 s_axi_wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  W payload.
REQ-010 s_axi_wvalid  in  1; s_axi_wready  out  1  W handshake.
REQ-011 s_axi_bid/bresp  out  ID_W/2; s_axi_bvalid  out  1; s_axi_bready  in  1  B channel.
REQ-012 wr_valid  out  1; wr_ready  in  1  backend write-beat handshake.
REQ-013 wr_addr/wr_data/wr_strb/wr_last  out  ADDR_W/DATA_W/DATA_W/8/1  backend beat payload.

Function
REQ-014 AW queue SHALL hold DEPTH entries {id,addr,len,size,burst}; s_axi_awready = queue not full; push on awvalid&&awready.
REQ-015 Full AW queue SHALL keep awready low even when a pop occurs in the same cycle.
REQ-016 W FSM SHALL have states W_IDLE and W_ACTIVE; W_IDLE with AW queue non-empty pops head into burst registers and moves to W_ACTIVE next cycle.
REQ-017 AW accepted at edge N into an empty queue SHALL give earliest s_axi_wready in cycle N+2.
REQ-018 In W_ACTIVE: wr_valid = s_axi_wvalid; s_axi_wready = wr_ready && !(final beat && B queue full); other states hold both low.
REQ-019 A beat SHALL transfer on wvalid&&wready; wr_data/wr_strb pass through s_axi_wdata/wstrb combinationally.
REQ-020 Beat counter (8 bit) SHALL start at 0; final beat is beat == awlen; wr_last = final beat.
REQ-021 After final beat FSM SHALL return to W_IDLE and may pop the next AW entry in that same W_IDLE cycle.
REQ-022 wr_addr SHALL start at awaddr; step S = 1<<awsize per beat.
REQ-023 FIXED (00): address constant. INCR (01): addr+S, modulo 2^ADDR_W, no 4 KB check.
REQ-024 WRAP (10): boundary B = (awlen+1)*S; next = (addr & ~(B-1)) | ((addr+S) & (B-1)).
REQ-025 Burst 11 SHALL be treated as INCR and flagged SLVERR.
REQ-026 awsize > log2(DATA_W/8) SHALL flag SLVERR; WRAP with awlen not in {1,3,7,15} SHALL flag SLVERR; beats still consumed.
REQ-027 wlast high before final beat, or low on final beat, SHALL flag SLVERR; burst length is always awlen+1, never truncated by wlast.
REQ-028 On final beat SHALL push {id, resp} into B queue; resp = 2'b10 if any flag set in that burst, else 2'b00.
REQ-029 s_axi_bvalid = B queue non-empty; bid/bresp from head; pop on bvalid&&bready; push and pop in the same cycle leave count unchanged.
REQ-030 Final beat at edge M into an empty B queue SHALL assert bvalid in cycle M+1.
REQ-031 bid/bresp SHALL stay stable while bvalid && !bready; B order equals AW acceptance order.
REQ-032 Error flags SHALL clear when a new burst loads.

Reset
REQ-033 aresetn low SHALL immediately force FSM W_IDLE, both queues empty, counters 0, awready/wready/bvalid/wr_valid/wr_last 0, bid/bresp/wr_addr 0.
REQ-034 Reset mid-burst SHALL abort the burst with no B response; awready SHALL rise the first cycle after deassertion.

Verification
REQ-035 INCR awaddr=0x100, len=3, size=2, 4 beats with wlast on beat 3 -> wr_addr 0x100,0x104,0x108,0x10C; bresp=00, bid=awid.
REQ-036 WRAP awaddr=0x38, len=3, size=2 -> wr_addr 0x38,0x3C,0x30,0x34; bresp=00.
REQ-037 INCR len=3, wlast on beat 1 -> 4 beats still accepted; bresp=10.
REQ-038 DEPTH+1 AW pushes with wvalid=0 -> awready low after DEPTH entries; B responses in issue order, IDs 1..5.
REQ-039 bready=0 while DEPTH single-beat bursts complete -> final beat of next burst stalls (wready=0) until one B pop.
REQ-040 aresetn low during beat 2 of len=7 -> no bvalid; awready=1 first cycle after release.

Source files
------------

// File: rtl/axi_slave_write_ctrl_if.sv
// AXI write channels (AW/W/B) plus the backend write-beat port of axi_slave_write_ctrl.
// The slave modport is the controller's view; master is the view of whoever drives it.
interface axi_slave_write_ctrl_if #(
    parameter int ID_W   = 12,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     s_axi_awid;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [7:0]          s_axi_awlen;
    logic [2:0]          s_axi_awsize;
    logic [1:0]          s_axi_awburst;
    logic                s_axi_awvalid;
    logic                s_axi_awready;

    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;

    logic [ID_W-1:0]     s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;

    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                wr_last;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        output wr_valid, wr_addr, wr_data, wr_strb, wr_last,
        input  wr_ready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        input  wr_valid, wr_addr, wr_data, wr_strb, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/axi_slave_write_ctrl.sv
// AXI write-slave front end: queues AW requests, steers W beats to a valid/ready
// backend with generated addresses, and returns B responses in AW order.
module axi_slave_write_ctrl #(
    parameter int ID_W   = 12,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  s_axi_aresetn,
    axi_slave_write_ctrl_if.slave bus
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0] BURST_FIXED    = 2'b00;
    localparam logic [1:0] BURST_WRAP     = 2'b10;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } aw_entry_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_entry_t;

    typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;

    w_state_t          r_state, w_state_nxt;

    aw_entry_t         r_aw_mem [DEPTH];
    logic [PTR_W-1:0]  r_aw_wr_ptr, r_aw_rd_ptr;
    logic [PTR_W:0]    r_aw_count;
    b_entry_t          r_b_mem [DEPTH];
    logic [PTR_W-1:0]  r_b_wr_ptr, r_b_rd_ptr;
    logic [PTR_W:0]    r_b_count;

    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat;
    logic              r_err;

    aw_entry_t         w_aw_in, w_aw_head;
    b_entry_t          w_b_in, w_b_head;
    logic              w_aw_full, w_aw_empty, w_aw_push, w_aw_pop, w_awready;
    logic              w_b_full, w_b_valid, w_b_push, w_b_pop;
    logic              w_final, w_beat, w_wlast_err, w_load_err;
    logic              w_wr_valid, w_wready;
    logic [ADDR_W-1:0] w_step, w_wrap_mask, w_addr_nxt;

    // ---------------- AW queue ----------------
    assign w_aw_in    = '{id: bus.s_axi_awid, addr: bus.s_axi_awaddr, len: bus.s_axi_awlen,
                          size: bus.s_axi_awsize, burst: bus.s_axi_awburst};
    assign w_aw_head  = r_aw_mem[r_aw_rd_ptr];
    assign w_aw_full  = (r_aw_count == FULL_CNT);
    assign w_aw_empty = (r_aw_count == '0);
    // Readiness depends on occupancy alone, so a pop never reopens a full queue early.
    assign w_awready  = s_axi_aresetn && !w_aw_full;
    assign w_aw_push  = bus.s_axi_awvalid && w_awready;
    assign w_aw_pop   = (r_state == W_IDLE) && !w_aw_empty;

    // NOTE: queue storage is not reset; pointers and counts alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (w_aw_push) r_aw_mem[r_aw_wr_ptr] <= w_aw_in;
        if (w_b_push)  r_b_mem[r_b_wr_ptr]   <= w_b_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_aw_wr_ptr <= '0;
            r_aw_rd_ptr <= '0;
            r_aw_count  <= '0;
        end else begin
            if (w_aw_push) r_aw_wr_ptr <= r_aw_wr_ptr + 1'b1;
            if (w_aw_pop)  r_aw_rd_ptr <= r_aw_rd_ptr + 1'b1;
            case ({w_aw_push, w_aw_pop})
                2'b10:   r_aw_count <= r_aw_count + 1'b1;
                2'b01:   r_aw_count <= r_aw_count - 1'b1;
                default: r_aw_count <= r_aw_count;
            endcase
        end
    end

    // ---------------- W burst FSM ----------------
    assign w_final     = (r_beat == r_len);
    assign w_beat      = bus.s_axi_wvalid && w_wready;
    assign w_wlast_err = (bus.s_axi_wlast != w_final);
    assign w_load_err  = (w_aw_head.size > 3'(MAX_SIZE)) || (w_aw_head.burst == 2'b11) ||
                         ((w_aw_head.burst == BURST_WRAP) &&
                          !(w_aw_head.len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    always_ff @(posedge clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) r_state <= W_IDLE;
        else                r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_valid  = 1'b0;
        w_wready    = 1'b0;
        case (r_state)
            W_IDLE: begin
                if (!w_aw_empty) w_state_nxt = W_ACTIVE;
            end
            W_ACTIVE: begin
                w_wr_valid = bus.s_axi_wvalid;
                w_wready   = bus.wr_ready && !(w_final && w_b_full);
                if (w_beat && w_final) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_step      = ADDR_W'(1) << r_size;
        w_wrap_mask = (ADDR_W'(r_len) + ADDR_W'(1)) * w_step - ADDR_W'(1);
        case (r_burst)
            BURST_FIXED: w_addr_nxt = r_addr;
            BURST_WRAP:  w_addr_nxt = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
            default:     w_addr_nxt = r_addr + w_step;
        endcase
    end

    always_ff @(posedge clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else if (w_aw_pop) begin
            r_id    <= w_aw_head.id;
            r_addr  <= w_aw_head.addr;
            r_len   <= w_aw_head.len;
            r_size  <= w_aw_head.size;
            r_burst <= w_aw_head.burst;
            r_beat  <= '0;
            r_err   <= w_load_err;
        end else if (w_beat && !w_final) begin
            r_beat  <= r_beat + 1'b1;
            r_addr  <= w_addr_nxt;
            r_err   <= r_err || w_wlast_err;
        end
    end

    // ---------------- B queue ----------------
    assign w_b_in    = '{id: r_id, resp: (r_err || w_wlast_err) ? RESP_SLVERR : RESP_OKAY};
    assign w_b_head  = r_b_mem[r_b_rd_ptr];
    assign w_b_full  = (r_b_count == FULL_CNT);
    assign w_b_valid = (r_b_count != '0);
    assign w_b_push  = w_beat && w_final;
    assign w_b_pop   = w_b_valid && bus.s_axi_bready;

    always_ff @(posedge clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_b_wr_ptr <= '0;
            r_b_rd_ptr <= '0;
            r_b_count  <= '0;
        end else begin
            if (w_b_push) r_b_wr_ptr <= r_b_wr_ptr + 1'b1;
            if (w_b_pop)  r_b_rd_ptr <= r_b_rd_ptr + 1'b1;
            case ({w_b_push, w_b_pop})
                2'b10:   r_b_count <= r_b_count + 1'b1;
                2'b01:   r_b_count <= r_b_count - 1'b1;
                default: r_b_count <= r_b_count;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.s_axi_awready = w_awready;
    assign bus.s_axi_wready  = w_wready;
    assign bus.s_axi_bvalid  = w_b_valid;
    assign bus.s_axi_bid     = w_b_valid ? w_b_head.id   : '0;
    assign bus.s_axi_bresp   = w_b_valid ? w_b_head.resp : '0;
    assign bus.wr_valid      = w_wr_valid;
    assign bus.wr_addr       = r_addr;
    assign bus.wr_data       = bus.s_axi_wdata;
    assign bus.wr_strb       = bus.s_axi_wstrb;
    assign bus.wr_last       = (r_state == W_ACTIVE) && w_final;
endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
// Directed bench for axi_slave_write_ctrl: address sequences, error responses,
// queue full/backpressure behaviour and mid-burst reset.
module tb_axi_slave_write_ctrl;
    localparam int ID_W = 12, ADDR_W = 32, DATA_W = 32, DEPTH = 4;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_slave_write_ctrl_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_slave_write_ctrl #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .s_axi_aresetn (rst_n),
        .bus           (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [ADDR_W-1:0]   cap_addr [16];
    logic                cap_last [16];
    logic [DATA_W-1:0]   cap_data [16];
    logic [DATA_W/8-1:0] cap_strb [16];
    logic [ID_W-1:0]     got_bid;
    logic [1:0]          got_bresp;

    task automatic init_inputs();
        bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
        bus.s_axi_awsize = '0; bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.wr_ready = 1'b1;
    endtask

    task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int t;
        @(negedge clk);
        bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len;
        bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
        t = 0;
        while (bus.s_axi_awready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_cmp++; n_mis++;
            $display("FAIL aw_accept id=%h: awready=%b, required 1", id, bus.s_axi_awready);
        end
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic run_beats(input int n, input logic [15:0] last_mask);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_axi_wvalid = 1'b1;
            bus.s_axi_wdata  = 32'hA000_0000 + 32'(i);
            bus.s_axi_wstrb  = 4'hF ^ 4'(i);
            bus.s_axi_wlast  = last_mask[i];
            t = 0;
            while (bus.s_axi_wready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin
                n_cmp++; n_mis++;
                $display("FAIL w_beat %0d: wready=%b, required 1", i, bus.s_axi_wready);
            end
            cap_addr[i] = bus.wr_addr;
            cap_last[i] = bus.wr_last;
            cap_data[i] = bus.wr_data;
            cap_strb[i] = bus.wr_strb;
            @(posedge clk); #1;
        end
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
    endtask

    task automatic get_b();
        int t;
        @(negedge clk);
        t = 0;
        while (bus.s_axi_bvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_cmp++; n_mis++;
            $display("FAIL b_wait: bvalid=%b, required 1", bus.s_axi_bvalid);
        end
        got_bid   = bus.s_axi_bid;
        got_bresp = bus.s_axi_bresp;
        bus.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic test_reset();
        init_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.s_axi_awready !== 1'b0) begin n_mis++; $display("FAIL rst_awready: got %b, expected 0", bus.s_axi_awready); end
        n_cmp++; if (bus.s_axi_wready !== 1'b0) begin n_mis++; $display("FAIL rst_wready: got %b, expected 0", bus.s_axi_wready); end
        n_cmp++; if (bus.s_axi_bvalid !== 1'b0) begin n_mis++; $display("FAIL rst_bvalid: got %b, expected 0", bus.s_axi_bvalid); end
        n_cmp++; if (bus.wr_valid !== 1'b0) begin n_mis++; $display("FAIL rst_wr_valid: got %b, expected 0", bus.wr_valid); end
        n_cmp++; if (bus.wr_last !== 1'b0) begin n_mis++; $display("FAIL rst_wr_last: got %b, expected 0", bus.wr_last); end
        n_cmp++; if (bus.wr_addr !== 32'h0) begin n_mis++; $display("FAIL rst_wr_addr: got %h, expected 0", bus.wr_addr); end
        n_cmp++; if (bus.s_axi_bid !== 12'h0 || bus.s_axi_bresp !== 2'b00) begin n_mis++; $display("FAIL rst_b_payload: got bid=%h bresp=%b, expected 0/00", bus.s_axi_bid, bus.s_axi_bresp); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.s_axi_awready !== 1'b1) begin n_mis++; $display("FAIL rst_release_awready: got %b, expected 1", bus.s_axi_awready); end
    endtask

    task automatic test_incr();
        logic [ADDR_W-1:0] exp_a [4];
        exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
        send_aw(12'h0A5, 32'h100, 8'd3, 3'd2, INCR);
        @(negedge clk);
        n_cmp++; if (bus.s_axi_wready !== 1'b0) begin n_mis++; $display("FAIL incr_wready_n1: got %b, expected 0", bus.s_axi_wready); end
        @(negedge clk);
        n_cmp++; if (bus.s_axi_wready !== 1'b1) begin n_mis++; $display("FAIL incr_wready_n2: got %b, expected 1", bus.s_axi_wready); end
        run_beats(4, 16'b1000);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cap_addr[i] !== exp_a[i]) begin n_mis++; $display("FAIL incr_addr[%0d]: got %h, expected %h", i, cap_addr[i], exp_a[i]); end
        end
        n_cmp++; if (cap_last[0] !== 1'b0 || cap_last[3] !== 1'b1) begin n_mis++; $display("FAIL incr_wr_last: got %b/%b, expected 0/1", cap_last[0], cap_last[3]); end
        n_cmp++; if (cap_data[2] !== 32'hA000_0002 || cap_strb[2] !== 4'hD) begin n_mis++; $display("FAIL incr_passthru: got %h/%h, expected a0000002/d", cap_data[2], cap_strb[2]); end
        @(negedge clk);
        n_cmp++; if (bus.s_axi_bvalid !== 1'b1) begin n_mis++; $display("FAIL incr_bvalid_m1: got %b, expected 1", bus.s_axi_bvalid); end
        get_b();
        n_cmp++; if (got_bid !== 12'h0A5) begin n_mis++; $display("FAIL incr_bid: got %h, expected 0a5", got_bid); end
        n_cmp++; if (got_bresp !== 2'b00) begin n_mis++; $display("FAIL incr_bresp: got %b, expected 00", got_bresp); end
        @(negedge clk);
        n_cmp++; if (bus.s_axi_bvalid !== 1'b0) begin n_mis++; $display("FAIL incr_bvalid_pop: got %b, expected 0", bus.s_axi_bvalid); end
    endtask

    task automatic test_wlast_err();
        send_aw(12'h03C, 32'h400, 8'd3, 3'd2, INCR);
        run_beats(4, 16'b0010);
        n_cmp++; if (cap_addr[3] !== 32'h40C || cap_last[3] !== 1'b1) begin n_mis++; $display("FAIL wlast_beat3: got addr=%h last=%b, expected 40c/1", cap_addr[3], cap_last[3]); end
        get_b();
        n_cmp++; if (got_bid !== 12'h03C || got_bresp !== 2'b10) begin n_mis++; $display("FAIL wlast_bresp: got %h/%b, expected 03c/10", got_bid, got_bresp); end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a [4];
        exp_a = '{32'h38, 32'h3C, 32'h30, 32'h34};
        send_aw(12'h007, 32'h38, 8'd3, 3'd2, WRAP);
        run_beats(4, 16'b1000);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cap_addr[i] !== exp_a[i]) begin n_mis++; $display("FAIL wrap_addr[%0d]: got %h, expected %h", i, cap_addr[i], exp_a[i]); end
        end
        get_b();
        n_cmp++; if (got_bid !== 12'h007 || got_bresp !== 2'b00) begin n_mis++; $display("FAIL wrap_bresp: got %h/%b, expected 007/00", got_bid, got_bresp); end
    endtask

    task automatic test_slverr();
        send_aw(12'h100, 32'h10, 8'd0, 3'd3, INCR);
        run_beats(1, 16'b1);
        get_b();
        n_cmp++; if (got_bresp !== 2'b10) begin n_mis++; $display("FAIL size_bresp: got %b, expected 10", got_bresp); end
        send_aw(12'h101, 32'h200, 8'd1, 3'd2, RSVD);
        run_beats(2, 16'b10);
        n_cmp++; if (cap_addr[1] !== 32'h204) begin n_mis++; $display("FAIL rsvd_addr: got %h, expected 204", cap_addr[1]); end
        get_b();
        n_cmp++; if (got_bresp !== 2'b10) begin n_mis++; $display("FAIL rsvd_bresp: got %b, expected 10", got_bresp); end
        send_aw(12'h102, 32'h300, 8'd2, 3'd2, WRAP);
        run_beats(3, 16'b100);
        get_b();
        n_cmp++; if (got_bresp !== 2'b10) begin n_mis++; $display("FAIL wraplen_bresp: got %b, expected 10", got_bresp); end
        send_aw(12'h103, 32'h500, 8'd1, 3'd2, FIXED);
        run_beats(2, 16'b10);
        n_cmp++; if (cap_addr[1] !== 32'h500) begin n_mis++; $display("FAIL fixed_addr: got %h, expected 500", cap_addr[1]); end
        get_b();
        n_cmp++; if (got_bresp !== 2'b00) begin n_mis++; $display("FAIL fixed_bresp: got %b, expected 00", got_bresp); end
    endtask

    task automatic test_aw_full();
        for (int i = 1; i <= 5; i++) send_aw(ID_W'(i), 32'h1000 + 32'(i * 16), 8'd0, 3'd2, INCR);
        @(negedge clk);
        n_cmp++; if (bus.s_axi_awready !== 1'b0) begin n_mis++; $display("FAIL full_awready: got %b, expected 0", bus.s_axi_awready); end
        for (int i = 1; i <= 5; i++) begin
            run_beats(1, 16'b1);
            n_cmp++; if (cap_addr[0] !== 32'h1000 + 32'(i * 16)) begin n_mis++; $display("FAIL full_addr[%0d]: got %h, expected %h", i, cap_addr[0], 32'h1000 + 32'(i * 16)); end
            if (i == 1) begin
                @(negedge clk);
                n_cmp++; if (bus.s_axi_awready !== 1'b0) begin n_mis++; $display("FAIL full_pop_awready: got %b, expected 0", bus.s_axi_awready); end
            end
            get_b();
            n_cmp++; if (got_bid !== ID_W'(i) || got_bresp !== 2'b00) begin n_mis++; $display("FAIL full_order[%0d]: got %h/%b, expected %h/00", i, got_bid, got_bresp, ID_W'(i)); end
        end
        @(negedge clk);
        n_cmp++; if (bus.s_axi_awready !== 1'b1) begin n_mis++; $display("FAIL full_drained_awready: got %b, expected 1", bus.s_axi_awready); end
    endtask

    task automatic test_b_backpressure();
        for (int i = 0; i < 4; i++) begin
            send_aw(12'h011 + ID_W'(i), 32'h2000 + 32'(i * 4), 8'd0, 3'd2, INCR);
            run_beats(1, 16'b1);
        end
        send_aw(12'h015, 32'h2010, 8'd0, 3'd2, INCR);
        @(negedge clk);
        bus.s_axi_wvalid = 1'b1; bus.s_axi_wlast = 1'b1; bus.s_axi_wdata = 32'h5555_AAAA; bus.s_axi_wstrb = 4'hF;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (bus.s_axi_wready !== 1'b0) begin n_mis++; $display("FAIL bfull_wready: got %b, expected 0", bus.s_axi_wready); end
            n_cmp++; if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_bid !== 12'h011) begin n_mis++; $display("FAIL bfull_head: got %b/%h, expected 1/011", bus.s_axi_bvalid, bus.s_axi_bid); end
        end
        bus.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.s_axi_wready !== 1'b1) begin n_mis++; $display("FAIL bfull_release: got %b, expected 1", bus.s_axi_wready); end
        @(posedge clk); #1;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_b();
            n_cmp++; if (got_bid !== 12'h012 + ID_W'(i) || got_bresp !== 2'b00) begin n_mis++; $display("FAIL bfull_drain[%0d]: got %h/%b, expected %h/00", i, got_bid, got_bresp, 12'h012 + ID_W'(i)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        send_aw(12'h02A, 32'h3000, 8'd7, 3'd2, INCR);
        run_beats(2, 16'b0);
        @(negedge clk);
        bus.s_axi_wvalid = 1'b1; bus.s_axi_wlast = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.wr_valid !== 1'b0 || bus.s_axi_wready !== 1'b0) begin n_mis++; $display("FAIL mid_rst_w: got wr_valid=%b wready=%b, expected 0/0", bus.wr_valid, bus.s_axi_wready); end
        n_cmp++; if (bus.s_axi_awready !== 1'b0 || bus.wr_addr !== 32'h0) begin n_mis++; $display("FAIL mid_rst_aw: got awready=%b wr_addr=%h, expected 0/0", bus.s_axi_awready, bus.wr_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.s_axi_awready !== 1'b1) begin n_mis++; $display("FAIL mid_release_awready: got %b, expected 1", bus.s_axi_awready); end
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.s_axi_bvalid !== 1'b0 || bus.s_axi_wready !== 1'b0) begin n_mis++; $display("FAIL mid_no_b: got bvalid=%b wready=%b, expected 0/0", bus.s_axi_bvalid, bus.s_axi_wready); end
        send_aw(12'h02B, 32'h3100, 8'd0, 3'd2, INCR);
        run_beats(1, 16'b1);
        get_b();
        n_cmp++; if (got_bid !== 12'h02B || got_bresp !== 2'b00) begin n_mis++; $display("FAIL mid_next_b: got %h/%b, expected 02b/00", got_bid, got_bresp); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wlast_err();
        test_wrap();
        test_slverr();
        test_aw_full();
        test_b_backpressure();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
